// File: rtl/fetch_pkg.sv
// Shared types and constants for the fetch PC sequencer.
package fetch_pkg;

  typedef enum logic [1:0] {
    BOOT = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2,
    ERR  = 2'd3
  } fetch_state_e;

  // Instruction width in bytes; the sequential fetch stride.
  localparam int unsigned INSTR_BYTES = 4;

  // First fetch address after reset unless the top is overridden.
  localparam logic [31:0] DEFAULT_RESET_VECTOR = 32'h0000_0000;

endpackage : fetch_pkg

// File: rtl/fetch_pc_sequencer_pc_incr.sv
// pc_incr: combinational PC + INSTR_BYTES adder; wraps modulo 2^XLEN.
//   pc_i     : current PC
//   sum_c_o  : pc_i + INSTR_BYTES (combinational)
module pc_incr
  import fetch_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic [XLEN-1:0] pc_i,
  output logic [XLEN-1:0] sum_c_o
);

  assign sum_c_o = pc_i + XLEN'(INSTR_BYTES);

endmodule : pc_incr

// File: rtl/fetch_pc_sequencer.sv
// fetch_pc_sequencer: owns the fetch PC, sequences BOOT/RUN/HALT/ERR and
// presents accepted fetch slots to the IF/ID register.
//   clk, rst_n     : clock, synchronous active-low reset
//   stall_i        : hold PC and IF/ID outputs
//   redirect_i     : load redirect_pc_i (branch/jal/jalr), flushes slot
//   redirect_pc_i  : redirect target; misaligned target traps to ERR
//   halt_i/resume_i: stop / restart fetching
//   imem_req_o     : fetch request (combinational from state)
//   imem_addr_o    : fetch address = pc_q (combinational)
//   imem_gnt_i     : imem accepts the request
//   fetch_valid_o  : pc_o/pc_plus4_o hold a valid slot
//   pc_o/pc_plus4_o: PC of last accepted fetch and its link value
//   misalign_o     : sticky misaligned-redirect flag
//   fetch_cnt_o    : accepted-fetch counter, wraps
module fetch_pc_sequencer
  import fetch_pkg::*;
#(
  parameter int unsigned     XLEN         = 32,
  parameter logic [XLEN-1:0] RESET_VECTOR = XLEN'(DEFAULT_RESET_VECTOR),
  parameter int unsigned     CNT_W        = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             stall_i,
  input  logic             redirect_i,
  input  logic [XLEN-1:0]  redirect_pc_i,
  input  logic             halt_i,
  input  logic             resume_i,
  output logic             imem_req_o,
  output logic [XLEN-1:0]  imem_addr_o,
  input  logic             imem_gnt_i,
  output logic             fetch_valid_o,
  output logic [XLEN-1:0]  pc_o,
  output logic [XLEN-1:0]  pc_plus4_o,
  output logic             misalign_o,
  output logic [CNT_W-1:0] fetch_cnt_o
);

  fetch_state_e     state_q, state_d;
  logic [XLEN-1:0]  pc_q, pc_d;
  logic [XLEN-1:0]  pc_out_q, pc_out_d;
  logic [XLEN-1:0]  pc_plus4_q, pc_plus4_d;
  logic             valid_q, valid_d;
  logic             misalign_q, misalign_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [XLEN-1:0]  pc_seq_c;
  logic             accept_c;

  pc_incr #(.XLEN(XLEN)) u_pc_incr (
    .pc_i    (pc_q),
    .sum_c_o (pc_seq_c)
  );

  assign accept_c = (state_q == RUN) & imem_gnt_i & ~stall_i & ~redirect_i;

  // Next-state: redirect > stall > halt > normal fetch.
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    pc_out_d   = pc_out_q;
    pc_plus4_d = pc_plus4_q;
    valid_d    = valid_q;
    misalign_d = misalign_q;
    cnt_d      = cnt_q;

    if (state_q == ERR) begin
      valid_d = 1'b0;
    end else if (redirect_i) begin
      valid_d = 1'b0;
      if (|redirect_pc_i[1:0]) begin
        state_d    = ERR;
        misalign_d = 1'b1;
      end else begin
        pc_d = redirect_pc_i;
        if (state_q == BOOT) state_d = RUN;
      end
    end else begin
      case (state_q)
        BOOT:    state_d = RUN;
        RUN:     if (halt_i) state_d = HALT;
        HALT:    if (resume_i) state_d = RUN;
        default: state_d = state_q;
      endcase
      // A stall freezes PC and the IF/ID slot even while halt transitions.
      if (!stall_i) begin
        valid_d = accept_c;
        if (accept_c) begin
          pc_d       = pc_seq_c;
          pc_out_d   = pc_q;
          pc_plus4_d = pc_seq_c;
          cnt_d      = cnt_q + CNT_W'(1);
        end
      end
    end
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= BOOT;
      pc_q       <= RESET_VECTOR;
      pc_out_q   <= '0;
      pc_plus4_q <= '0;
      valid_q    <= 1'b0;
      misalign_q <= 1'b0;
      cnt_q      <= '0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      pc_out_q   <= pc_out_d;
      pc_plus4_q <= pc_plus4_d;
      valid_q    <= valid_d;
      misalign_q <= misalign_d;
      cnt_q      <= cnt_d;
    end
  end

  assign imem_req_o    = (state_q == RUN);
  assign imem_addr_o   = pc_q;
  assign fetch_valid_o = valid_q;
  assign pc_o          = pc_out_q;
  assign pc_plus4_o    = pc_plus4_q;
  assign misalign_o    = misalign_q;
  assign fetch_cnt_o   = cnt_q;

endmodule : fetch_pc_sequencer

// File: tb/tb_fetch_pc_sequencer.sv
// Bench for fetch_pc_sequencer: directed scenarios then random stimulus,
// all checked against a flag-based behavioural model. A second instance
// with a 4-bit counter exercises the counter wrap.
module tb_fetch_pc_sequencer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        stall, redir, halt, resume, gnt;
  logic [31:0] rpc;

  logic        req, valid, mis;
  logic [31:0] addr, pc_out, pc4, cnt;
  logic        w_req, w_valid, w_mis;
  logic [31:0] w_addr, w_pc_out, w_pc4;
  logic [3:0]  w_cnt;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  fetch_pc_sequencer dut (
    .clk(clk), .rst_n(rst_n), .stall_i(stall), .redirect_i(redir),
    .redirect_pc_i(rpc), .halt_i(halt), .resume_i(resume),
    .imem_req_o(req), .imem_addr_o(addr), .imem_gnt_i(gnt),
    .fetch_valid_o(valid), .pc_o(pc_out), .pc_plus4_o(pc4),
    .misalign_o(mis), .fetch_cnt_o(cnt)
  );

  fetch_pc_sequencer #(.CNT_W(4)) dut_w (
    .clk(clk), .rst_n(rst_n), .stall_i(stall), .redirect_i(redir),
    .redirect_pc_i(rpc), .halt_i(halt), .resume_i(resume),
    .imem_req_o(w_req), .imem_addr_o(w_addr), .imem_gnt_i(gnt),
    .fetch_valid_o(w_valid), .pc_o(w_pc_out), .pc_plus4_o(w_pc4),
    .misalign_o(w_mis), .fetch_cnt_o(w_cnt)
  );

  // Behavioural model: mode flags plus architectural values.
  bit          m_boot, m_halted, m_err, m_valid, m_mis;
  logic [31:0] m_pc, m_pc_o, m_pc4, m_cnt;

  task automatic check_eq(input string tag, input logic [31:0] got,
                          input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=0x%08h exp=0x%08h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_step();
    bit running;
    if (!rst_n) begin
      m_boot = 1; m_halted = 0; m_err = 0; m_valid = 0; m_mis = 0;
      m_pc = 32'h0; m_pc_o = 32'h0; m_pc4 = 32'h0; m_cnt = 32'h0;
      return;
    end
    if (m_err) return;
    running = !m_boot && !m_halted;
    if (redir) begin
      m_valid = 0;
      if (rpc % 4 != 0) begin
        m_err = 1; m_mis = 1; m_boot = 0; m_halted = 0;
      end else begin
        m_pc = rpc;
        m_boot = 0;
      end
      return;
    end
    if (m_boot) begin
      m_boot = 0;
      return;
    end
    if (m_halted) begin
      if (resume) m_halted = 0;
      if (!stall) m_valid = 0;
      return;
    end
    if (running && halt) m_halted = 1;
    if (stall) return;
    if (gnt) begin
      m_pc_o = m_pc;
      m_pc4  = m_pc + 32'd4;
      m_pc   = m_pc + 32'd4;
      m_valid = 1;
      m_cnt  = m_cnt + 32'd1;
    end else begin
      m_valid = 0;
    end
  endtask

  task automatic compare_all();
    bit exp_req;
    exp_req = !m_boot && !m_halted && !m_err;
    check_eq("imem_req", 32'(req), 32'(exp_req));
    check_eq("imem_addr", addr, m_pc);
    check_eq("fetch_valid", 32'(valid), 32'(m_valid));
    check_eq("pc_o", pc_out, m_pc_o);
    check_eq("pc_plus4", pc4, m_pc4);
    check_eq("misalign", 32'(mis), 32'(m_mis));
    check_eq("fetch_cnt", cnt, m_cnt);
    check_eq("fetch_cnt_w4", 32'(w_cnt), 32'(m_cnt[3:0]));
  endtask

  // One clock: model follows the same edge, outputs checked at negedge.
  task automatic tick();
    @(posedge clk);
    model_step();
    @(negedge clk);
    compare_all();
  endtask

  task automatic idle_inputs();
    stall = 0; redir = 0; halt = 0; resume = 0; rpc = 32'h0;
  endtask

  initial begin
    rst_n = 0; gnt = 0;
    idle_inputs();
    @(negedge clk);
    tick();
    check_eq("rst_addr", addr, 32'h0);
    check_eq("rst_req", 32'(req), 32'h0);

    // Boot and sequential fetch with constant grant.
    rst_n = 1; gnt = 1;
    tick();
    check_eq("t1_addr0", addr, 32'h0);
    tick();
    check_eq("t1_addr1", addr, 32'h4);
    check_eq("t1_pc_o", pc_out, 32'h0);
    check_eq("t1_valid", 32'(valid), 32'h1);
    tick();
    tick();
    check_eq("t1_cnt", cnt, 32'd3);
    tick();
    check_eq("t2_pc_q", addr, 32'h10);

    // Stall for three cycles at pc_q=0x10.
    stall = 1;
    repeat (3) tick();
    check_eq("t2_hold_addr", addr, 32'h10);
    check_eq("t2_hold_pc_o", pc_out, 32'hC);
    stall = 0;
    tick();
    check_eq("t2_pc_o", pc_out, 32'h10);
    check_eq("t2_pc4", pc4, 32'h14);

    // Redirect beats stall and discards the grant.
    stall = 1; redir = 1; rpc = 32'h200;
    tick();
    check_eq("t3_valid", 32'(valid), 32'h0);
    check_eq("t3_addr", addr, 32'h200);
    idle_inputs();

    // Halt at 0x40, then resume.
    redir = 1; rpc = 32'h40;
    tick();
    idle_inputs();
    gnt = 0; halt = 1;
    tick();
    halt = 0; gnt = 1;
    repeat (5) begin
      tick();
      check_eq("t5_req", 32'(req), 32'h0);
      check_eq("t5_addr", addr, 32'h40);
    end
    resume = 1;
    tick();
    resume = 0;
    check_eq("t5_resume_addr", addr, 32'h40);
    tick();
    check_eq("t5_pc_o", pc_out, 32'h40);

    // PC wrap at the top of the address space.
    redir = 1; rpc = 32'hFFFF_FFFC;
    tick();
    idle_inputs();
    tick();
    check_eq("t6_pc4", pc4, 32'h0);
    check_eq("t6_addr", addr, 32'h0);

    // Misaligned redirect traps until reset.
    redir = 1; rpc = 32'h202;
    tick();
    idle_inputs();
    check_eq("t4_mis", 32'(mis), 32'h1);
    repeat (3) begin
      tick();
      check_eq("t4_req", 32'(req), 32'h0);
    end
    rst_n = 0;
    tick();
    check_eq("t4_mis_clr", 32'(mis), 32'h0);
    rst_n = 1;
    tick();
    check_eq("t4_addr", addr, 32'h0);

    // Random phase.
    for (int i = 0; i < 4000; i++) begin
      rst_n  = ($urandom_range(99) >= 2);
      stall  = ($urandom_range(99) < 20);
      redir  = ($urandom_range(99) < 8);
      halt   = ($urandom_range(99) < 5);
      resume = ($urandom_range(99) < 20);
      gnt    = ($urandom_range(99) < 75);
      rpc    = $urandom & 32'hFFFF_FFFC;
      if ($urandom_range(9) == 0) rpc = 32'hFFFF_FFF0 | (rpc & 32'hC);
      if ($urandom_range(19) == 0) rpc = rpc | 32'($urandom_range(3));
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule : tb_fetch_pc_sequencer
